mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_rr_picker.sv | 32 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared sizing and state encoding for the single-port node memory and its clients.
package mem_arbiter_pkg;

  localparam int ARB_N_REQ  = 4;
  localparam int ARB_ADDR_W = 11;
  localparam int WORD_WIDTH = 16;
  localparam int ARB_DATA_W = WORD_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin winner: first requester at or after ptr, wrapping.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             vld,
  output logic [PTR_W-1:0] idx
);

  int               j;
  logic [PTR_W-1:0] jj;

  // Scan from the farthest offset down so the nearest hit is the last write.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    j   = 0;
    jj  = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      jj = PTR_W'(j);
      if (req[jj]) begin
        vld = 1'b1;
        idx = jj;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving N_REQ requesters access to one single-port memory.
//   state    | meaning
//   ST_IDLE  | no access in flight; pick a winner when any req is high
//   ST_ISSUE | captured command presented to the memory, write strobe here
//   ST_RESP  | memory answers; ack to winner, maybe continue a locked burst
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N_REQ  = ARB_N_REQ,
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    lock,
  input  logic [N_REQ-1:0]    wr,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    ack,
  output logic [DATA_W-1:0]   rdata,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wr_en,
  output logic [DATA_W-1:0]   mem_data_in,
  input  logic [DATA_W-1:0]   mem_data_out,
  output logic                busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  win_q, win_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              pick_vld;
  logic [PTR_W-1:0]  pick_idx;
  logic [PTR_W-1:0]  cap_idx;
  logic              cap_wr;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_picker (
    .req (req),
    .ptr (ptr_q),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  // New winner in IDLE, same requester when a locked burst continues from RESP.
  assign cap_idx   = (state_q == ST_IDLE) ? pick_idx : win_q;
  assign cap_wr    = wr[cap_idx];
  assign cap_addr  = addr[int'(cap_idx)*ADDR_W +: ADDR_W];
  assign cap_wdata = wdata[int'(cap_idx)*DATA_W +: DATA_W];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gnt     = '0;
    ack     = '0;
    rdata   = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          win_d   = pick_idx;
          wr_d    = cap_wr;
          addr_d  = cap_addr;
          wdata_d = cap_wdata;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        gnt[win_q] = 1'b1;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        gnt[win_q] = 1'b1;
        ack[win_q] = 1'b1;
        if (!wr_q) rdata = mem_data_out;
        rdata_d = rdata;
        if (lock[win_q] && req[win_q]) begin
          wr_d    = cap_wr;
          addr_d  = cap_addr;
          wdata_d = cap_wdata;
          state_d = ST_ISSUE;
        end else begin
          if (win_q == PTR_W'(N_REQ - 1)) ptr_d = '0;
          else                            ptr_d = win_q + PTR_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Gated by rst directly so a reset landing mid-ISSUE never commits a write.
  assign mem_wr_en   = (state_q == ST_ISSUE) && wr_q && !rst;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random request rounds against a transaction model.
module tb_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 11;
  localparam int DW = 16;

  logic              clock = 1'b0;
  logic              rst;
  logic [N-1:0]      req, lock, wr, gnt, ack;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [DW-1:0]     rdata, mem_data_in, mem_data_out;
  logic [AW-1:0]     mem_addr;
  logic              mem_wr_en, busy;

  logic [DW-1:0]     tb_mem  [2**AW];
  logic [DW-1:0]     ref_mem [2**AW];
  logic [AW-1:0]     av [N];
  logic [DW-1:0]     dv [N];
  int                n_checks = 0;
  int                n_errors = 0;
  int                ref_ptr;
  logic [DW-1:0]     ref_rdata;

  mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock        (clock),
    .rst          (rst),
    .req          (req),
    .lock         (lock),
    .wr           (wr),
    .addr         (addr),
    .wdata        (wdata),
    .gnt          (gnt),
    .ack          (ack),
    .rdata        (rdata),
    .mem_addr     (mem_addr),
    .mem_wr_en    (mem_wr_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // Single-port memory with registered read, old data on a same-cycle write.
  always @(posedge clock) begin
    mem_data_out <= tb_mem[mem_addr];
    if (mem_wr_en) tb_mem[mem_addr] = mem_data_in;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tb_mem[a]  = d;
    ref_mem[a] = d;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    wr[i]  = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  // All requesters in mask raise req together from IDLE and hold until acked.
  task automatic run_round(input logic [N-1:0] mask, input logic [N-1:0] wv);
    int exp_q[$];
    int cyc, exp_c, n_we, n_wr, w, j;
    cyc = 0; exp_c = 2; n_we = 0; n_wr = 0;
    for (int k = 0; k < N; k++) begin
      j = (ref_ptr + k) % N;
      if (mask[j]) begin
        exp_q.push_back(j);
        if (wv[j]) n_wr++;
      end
    end
    for (int i = 0; i < N; i++) if (mask[i]) set_req(i, wv[i], av[i], dv[i]);
    while (exp_q.size() > 0 && cyc < 3*N + 4) begin
      @(negedge clock);
      cyc++;
      if (mem_wr_en) n_we++;
      if (ack != '0) begin
        w = exp_q.pop_front();
        check("ack_who", 32'(ack), 32'(1) << w);
        check("gnt_at_ack", 32'(gnt), 32'(1) << w);
        check("ack_cycle", cyc, exp_c);
        exp_c += 3;
        if (wv[w]) begin
          ref_mem[av[w]] = dv[w];
          check("rdata_hold", 32'(rdata), 32'(ref_rdata));
        end else begin
          ref_rdata = ref_mem[av[w]];
          check("rdata", 32'(rdata), 32'(ref_rdata));
        end
        req[w]  = 1'b0;
        ref_ptr = (w + 1) % N;
      end
    end
    check("round_done", exp_q.size(), 0);
    check("wr_pulses", n_we, n_wr);
    req = '0;
    @(negedge clock);
    check("idle_after", {27'd0, busy, gnt}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, nb, exp_c;
    bit done0;
    logic [N-1:0] mask, wv;

    rst = 1'b1; req = '0; lock = '0; wr = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 2**AW; i++) begin
      tb_mem[i]  = '0;
      ref_mem[i] = '0;
    end
    repeat (2) @(negedge clock);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_din", 32'(mem_data_in), 0);
    check("rst_we", 32'(mem_wr_en), 0);
    rst = 1'b0; ref_ptr = 0; ref_rdata = '0;
    @(negedge clock);

    // four simultaneous reads from ptr 0
    for (int i = 0; i < N; i++) begin
      preload(AW'(11'h200 + i), DW'(100 + i));
      av[i] = AW'(11'h200 + i);
      dv[i] = '0;
    end
    run_round(4'b1111, 4'b0000);
    // 0 before 3 only if ptr wrapped back to 0
    run_round(4'b1001, 4'b0000);

    // write 51 then read it back via requester 0
    av[0] = 11'h048; dv[0] = 16'd51;
    run_round(4'b0001, 4'b0001);
    check("wr_mem_51", 32'(tb_mem[11'h048]), 51);
    run_round(4'b0001, 4'b0000);
    check("rd_51", 32'(rdata), 51);

    // single read of preloaded word
    preload(11'h68A, 16'd5);
    av[1] = 11'h68A;
    run_round(4'b0010, 4'b0000);
    check("rd_5", 32'(rdata), 5);

    // locked burst from requester 2 with requester 0 waiting (ptr is 2 here)
    preload(11'h148, 16'h1111);
    preload(11'h149, 16'h2222);
    preload(11'h14A, 16'h3333);
    preload(11'h010, 16'h0A0A);
    set_req(2, 1'b0, 11'h148, '0);
    lock[2] = 1'b1;
    set_req(0, 1'b0, 11'h010, '0);
    cyc = 0; nb = 0; exp_c = 2; done0 = 1'b0;
    while (!done0 && cyc < 30) begin
      @(negedge clock);
      cyc++;
      check("burst_stray", 32'(ack[1] | ack[3]), 0);
      if (ack[2]) begin
        check("burst_cycle", cyc, exp_c);
        check("burst_rdata", 32'(rdata), 32'(ref_mem[AW'(11'h148 + nb)]));
        nb++;
        exp_c += 2;
        if (nb < 3) addr[2*AW +: AW] = AW'(11'h148 + nb);
        else begin
          req[2] = 1'b0; lock[2] = 1'b0;
          exp_c = cyc + 3;
        end
      end else if (ack[0]) begin
        check("burst_count", nb, 3);
        check("after_burst_cycle", cyc, exp_c);
        check("after_burst_rdata", 32'(rdata), 32'h0A0A);
        req[0] = 1'b0;
        done0 = 1'b1;
      end
    end
    check("burst_done", 32'(done0), 1);
    @(negedge clock);
    check("burst_idle", 32'(busy), 0);
    ref_ptr = 1; ref_rdata = 16'h0A0A;

    // reset lands during ISSUE of a write
    preload(11'h008, 16'hBEEF);
    set_req(3, 1'b1, 11'h008, 16'h1234);
    @(negedge clock);
    check("issue_we", 32'(mem_wr_en), 1);
    rst = 1'b1;
    req = '0;
    #1;
    check("we_gated", 32'(mem_wr_en), 0);
    @(negedge clock);
    check("abort_busy", 32'(busy), 0);
    check("abort_ack", 32'(ack), 0);
    check("abort_gnt", 32'(gnt), 0);
    check("abort_mem", 32'(tb_mem[11'h008]), 32'hBEEF);
    check("abort_rdata", 32'(rdata), 0);
    rst = 1'b0; ref_ptr = 0; ref_rdata = '0;
    @(negedge clock);

    // requester 3 drops req while its read is in flight
    preload(11'h300, 16'h0777);
    set_req(3, 1'b0, 11'h300, '0);
    @(negedge clock);
    req[3] = 1'b0;
    @(negedge clock);
    check("drop_ack", 32'(ack), 32'b1000);
    check("drop_rdata", 32'(rdata), 32'h0777);
    @(negedge clock);
    check("drop_idle", 32'(busy), 0);
    ref_ptr = 0; ref_rdata = 16'h0777;

    // random rounds over a small address window to create read-after-write hazards
    for (int r = 0; r < 40; r++) begin
      mask = N'($urandom_range(1, 15));
      wv   = N'($urandom);
      for (int i = 0; i < N; i++) begin
        av[i] = AW'(11'h100 + $urandom_range(0, 7));
        dv[i] = DW'($urandom);
      end
      run_round(mask, wv);
    end
    for (int a = 11'h100; a < 11'h108; a++)
      check("final_mem", 32'(tb_mem[a]), 32'(ref_mem[a]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
